// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: two-port (instruction/data) arbiter in front of one
// single-ported synchronous-read block RAM. It alternates grants on ties,
// inserts WAIT_CYCLES wait states and answers illegal requests with error.
module elbeth_mem_arbiter #(
  parameter int MEM_WORDS   = 16384,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_en,
  input  logic [13:0] imem_addr,
  input  logic [3:0]  imem_rw,
  input  logic [31:0] imem_wdata,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_error,
  input  logic        dmem_en,
  input  logic [13:0] dmem_addr,
  input  logic [3:0]  dmem_rw,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,
  output logic        ram_en,
  output logic [13:0] ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t      state;
  logic        gnt_d;       // port being served: 1 = dmem, 0 = imem
  logic        last_d;      // port granted most recently
  logic [3:0]  wait_cnt;
  logic [31:0] imem_rdata_q;
  logic [31:0] dmem_rdata_q;

  logic        any_req;
  logic        pick_d;
  logic [13:0] sel_addr;
  logic [3:0]  sel_rw;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  // Grant selection: a lone requester wins; a tie goes to the port not granted last.
  always_comb begin
    any_req   = imem_en | dmem_en;
    pick_d    = dmem_en & (~imem_en | ~last_d);
    sel_addr  = pick_d ? dmem_addr  : imem_addr;
    sel_rw    = pick_d ? dmem_rw    : imem_rw;
    sel_wdata = pick_d ? dmem_wdata : imem_wdata;
    // Out-of-range address, or any write attempt on the read-only instruction port.
    sel_bad   = ({18'd0, sel_addr} >= 32'(MEM_WORDS)) | (~pick_d & (imem_rw != 4'd0));
  end

  // RAM read data is only valid during RESP, so the served port sees it directly
  // in that cycle; the captured copy holds it until that port's next completion.
  assign imem_rdata = (state == RESP && !gnt_d) ? ram_rdata : imem_rdata_q;
  assign dmem_rdata = (state == RESP &&  gnt_d) ? ram_rdata : dmem_rdata_q;

  // Controller FSM with registered RAM strobes and handshake pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      gnt_d        <= 1'b0;
      last_d       <= 1'b0;
      wait_cnt     <= 4'd0;
      imem_rdata_q <= 32'd0;
      dmem_rdata_q <= 32'd0;
      imem_ready   <= 1'b0;
      imem_error   <= 1'b0;
      dmem_ready   <= 1'b0;
      dmem_error   <= 1'b0;
      ram_en       <= 1'b0;
      ram_addr     <= 14'd0;
      ram_we       <= 4'd0;
      ram_wdata    <= 32'd0;
    end else begin
      imem_ready <= 1'b0;
      imem_error <= 1'b0;
      dmem_ready <= 1'b0;
      dmem_error <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_d     <= pick_d;
            last_d    <= pick_d;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            if (sel_bad) begin
              // Error response is raised on entry to ERR; RAM stays idle.
              state <= ERR;
              if (pick_d) begin
                dmem_ready   <= 1'b1;
                dmem_error   <= 1'b1;
                dmem_rdata_q <= 32'd0;
              end else begin
                imem_ready   <= 1'b1;
                imem_error   <= 1'b1;
                imem_rdata_q <= 32'd0;
              end
            end else begin
              state    <= ACCESS;
              ram_en   <= 1'b1;
              ram_we   <= sel_rw;
              wait_cnt <= 4'(WAIT_CYCLES);
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state  <= RESP;
            ram_en <= 1'b0;
            ram_we <= 4'd0;
            if (gnt_d) dmem_ready <= 1'b1;
            else       imem_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (gnt_d) dmem_rdata_q <= ram_rdata;
          else       imem_rdata_q <= ram_rdata;
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
